// File: rtl/sd_spi_pkg.sv
// Shared constants and state type for the SD SPI-mode card responder.
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;

  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;
  localparam logic [7:0] CMD0_CRC   = 8'h95;

  typedef enum logic [2:0] {
    HUNT,
    RX,
    DECODE,
    GAP,
    TX
  } state_t;

endpackage

// File: rtl/sd_spi_rsp_tx.sv
// Loadable MSB-first response serializer: idles dout high for gap_bits
// cycles after load, then shifts out 8 or 40 bits. abort returns to idle.
module sd_spi_rsp_tx (
  input  logic        sdclk,
  input  logic        reset,
  input  logic        abort,
  input  logic        load,
  input  logic [39:0] rsp,
  input  logic        len_is_40,
  input  logic [6:0]  gap_bits,
  output logic        dout,
  output logic        busy
);

  logic [39:0] sr;
  logic [6:0]  gap_cnt;
  logic [5:0]  bit_cnt;

  // Gap countdown, then shift; dout is 1 whenever nothing is being sent.
  always_ff @(posedge sdclk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      dout    <= 1'b1;
    end else if (abort) begin
      gap_cnt <= '0;
      bit_cnt <= '0;
      dout    <= 1'b1;
    end else if (load) begin
      sr      <= rsp;
      gap_cnt <= gap_bits;
      bit_cnt <= len_is_40 ? 6'd40 : 6'd8;
      dout    <= 1'b1;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 7'd1;
      dout    <= 1'b1;
    end else if (bit_cnt != '0) begin
      dout    <= sr[39];
      sr      <= {sr[38:0], 1'b0};
      bit_cnt <= bit_cnt - 6'd1;
    end else begin
      dout    <= 1'b1;
    end
  end

  assign busy = (gap_cnt != '0) || (bit_cnt != '0);

endmodule

// File: rtl/sd_spi_card_responder.sv
// Card-side SD SPI-mode responder: receives 48-bit command frames and
// answers CMD0/CMD8/CMD55/ACMD41 with R1/R7 after an Ncr gap.
module sd_spi_card_responder
  import sd_spi_pkg::*;
#(
  parameter int unsigned NCR_BYTES   = 1,
  parameter int unsigned ACMD41_BUSY = 2
) (
  input  logic        sdclk,
  input  logic        reset,
  input  logic        cs,
  input  logic        din,
  output logic        dout,
  output logic        spi_mode,
  output logic        in_idle,
  output logic        init_done,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg
);

  localparam logic [6:0] GAP_BITS = 7'(8 * NCR_BYTES);

  state_t      state, state_nx;
  logic [47:0] rx_sr;
  logic [5:0]  rx_cnt;
  logic [6:0]  gap_cnt;
  logic [3:0]  busy_cnt, busy_nx;
  logic        app, app_nx;
  logic        idle_nx, done_nx, len40;
  logic [7:0]  r1;
  logic [39:0] rsp_nx;
  logic        accept, take, tx_busy;

  wire [5:0]  f_idx = rx_sr[45:40];
  wire [31:0] f_arg = rx_sr[39:8];
  wire [7:0]  f_crc = rx_sr[7:0];

  // Framing check; before CMD0 only a correctly-CRC'd CMD0 is honoured.
  assign accept = !rx_sr[47] && rx_sr[46] && rx_sr[0] &&
                  (spi_mode || (f_idx == CMD0 && f_crc == CMD0_CRC));
  assign take   = (state == DECODE) && accept && !cs;

  // Response selection and the flag values that take effect on acceptance.
  always_comb begin
    r1      = '0;
    len40   = 1'b0;
    idle_nx = in_idle;
    done_nx = init_done;
    busy_nx = busy_cnt;
    app_nx  = 1'b0;
    case (f_idx)
      CMD0: begin
        idle_nx = 1'b1;
        done_nx = 1'b0;
        busy_nx = 4'(ACMD41_BUSY);
        r1      = R1_IDLE;
      end
      CMD8: begin
        if (f_arg[11:8] == 4'h1) begin
          r1    = {7'b0, in_idle};
          len40 = 1'b1;
        end else begin
          r1 = R1_ILLEGAL | {7'b0, in_idle};
        end
      end
      CMD55: begin
        app_nx = 1'b1;
        r1     = {7'b0, in_idle};
      end
      CMD41: begin
        if (!app) begin
          r1 = R1_ILLEGAL | {7'b0, in_idle};
        end else if (init_done) begin
          r1 = '0;
        end else if (busy_cnt != '0) begin
          busy_nx = busy_cnt - 4'd1;
          r1      = R1_IDLE;
        end else begin
          idle_nx = 1'b0;
          done_nx = 1'b1;
          r1      = '0;
        end
      end
      default: r1 = R1_ILLEGAL | {7'b0, in_idle};
    endcase
    rsp_nx = len40 ? {r1, 4'h0, 16'h0, f_arg[11:0]} : {r1, 32'h0};
  end

  // Next-state logic; cs high forces HUNT from any state.
  always_comb begin
    state_nx = state;
    if (cs) begin
      state_nx = HUNT;
    end else begin
      case (state)
        HUNT:    if (!din) state_nx = RX;
        RX:      if (rx_cnt == 6'd47) state_nx = DECODE;
        DECODE:  state_nx = accept ? GAP : HUNT;
        GAP:     if (gap_cnt == '0) state_nx = TX;
        TX:      if (!tx_busy) state_nx = HUNT;
        default: state_nx = HUNT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sdclk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nx;
  end

  // Receive shifter and gap tracking; HUNT shifts too so the start bit lands in place.
  always_ff @(posedge sdclk or posedge reset) begin
    if (reset) begin
      rx_sr   <= '1;
      rx_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == HUNT || state == RX) rx_sr <= {rx_sr[46:0], din};
      if (state == HUNT)    rx_cnt <= 6'd1;
      else if (state == RX) rx_cnt <= rx_cnt + 6'd1;
      if (state == DECODE)                 gap_cnt <= GAP_BITS - 7'd1;
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 7'd1;
    end
  end

  // Card flags and command latches, updated only on an accepted frame.
  always_ff @(posedge sdclk or posedge reset) begin
    if (reset) begin
      spi_mode  <= 1'b0;
      in_idle   <= 1'b0;
      init_done <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_index <= '0;
      cmd_arg   <= '0;
      busy_cnt  <= 4'(ACMD41_BUSY);
      app       <= 1'b0;
    end else begin
      cmd_valid <= take;
      if (take) begin
        spi_mode  <= spi_mode | (f_idx == CMD0);
        in_idle   <= idle_nx;
        init_done <= done_nx;
        busy_cnt  <= busy_nx;
        app       <= app_nx;
        cmd_index <= f_idx;
        cmd_arg   <= f_arg;
      end
    end
  end

  sd_spi_rsp_tx u_tx (
    .sdclk     (sdclk),
    .reset     (reset),
    .abort     (cs),
    .load      (take),
    .rsp       (rsp_nx),
    .len_is_40 (len40),
    .gap_bits  (GAP_BITS),
    .dout      (dout),
    .busy      (tx_busy)
  );

endmodule
